// File: rtl/fpu_ret_merge.sv
// Retire-status merge queue for FP lanes u1/u3/u5: compacts up to three retire
// words per cycle into a circular buffer and presents the two oldest entries.
module fpu_ret_merge #(
   parameter int DEPTH = 8,
   parameter int RET_W = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [RET_W-1:0]       u1_ret,
   input  logic                   u1_ret_en,
   input  logic [RET_W-1:0]       u3_ret,
   input  logic                   u3_ret_en,
   input  logic [RET_W-1:0]       u5_ret,
   input  logic                   u5_ret_en,
   output logic [RET_W-1:0]       out0_ret,
   output logic                   out0_vld,
   output logic [RET_W-1:0]       out1_ret,
   output logic                   out1_vld,
   input  logic [1:0]             out_take,
   output logic                   stall,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [RET_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [AW-1:0]    head_p1;
   logic [CW-1:0]    count_q, count_d;
   logic             stall_q, stall_d;
   logic             err_q, err_d;

   logic [1:0]       take_n;
   logic             take_err;
   logic [CW-1:0]    space;
   logic [1:0]       slot3, slot5;
   logic             wr1, wr3, wr5;
   logic [1:0]       n_acc;
   logic             ovf;
   logic [AW-1:0]    addr1, addr3, addr5;

   // Outputs come from registered state only; no input reaches them combinationally.
   assign head_p1  = head_q + AW'(1);
   assign out0_ret = mem_q[head_q];
   assign out1_ret = mem_q[head_p1];
   assign out0_vld = (count_q != '0);
   assign out1_vld = (count_q >= CW'(2));
   assign count    = count_q;
   assign stall    = stall_q;
   assign err      = err_q;

   always_comb begin
      take_n   = 2'd0;
      take_err = 1'b0;
      case (out_take)
         2'b00: ;
         2'b01: begin
            if (out0_vld) take_n = 2'd1;
            else          take_err = 1'b1;
         end
         2'b11: begin
            if (out1_vld) begin
               take_n = 2'd2;
            end else begin
               take_err = 1'b1;
               if (out0_vld) take_n = 2'd1;
            end
         end
         default: take_err = 1'b1;
      endcase

      // Slots freed by this cycle's dequeue are reusable by this cycle's enqueue.
      space = DEPTH_C - count_q + CW'(take_n);

      slot3 = {1'b0, u1_ret_en};
      slot5 = {1'b0, u1_ret_en} + {1'b0, u3_ret_en};

      wr1 = u1_ret_en && (space != '0);
      wr3 = u3_ret_en && (CW'(slot3) < space);
      wr5 = u5_ret_en && (CW'(slot5) < space);

      n_acc = {1'b0, wr1} + {1'b0, wr3} + {1'b0, wr5};
      ovf   = (u1_ret_en && !wr1) || (u3_ret_en && !wr3) || (u5_ret_en && !wr5);

      addr1 = tail_q;
      addr3 = tail_q + AW'(slot3);
      addr5 = tail_q + AW'(slot5);

      head_d  = head_q + AW'(take_n);
      tail_d  = tail_q + AW'(n_acc);
      count_d = count_q + CW'(n_acc) - CW'(take_n);
      stall_d = (DEPTH_C - count_d) < CW'(3);
      err_d   = err_q | take_err | ovf;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (wr1) mem_q[addr1] <= u1_ret;
      if (wr3) mem_q[addr3] <= u3_ret;
      if (wr5) mem_q[addr5] <= u5_ret;
   end

endmodule

// File: doc/fpu_ret_merge.md
# fpu_ret_merge

Retire-status merge queue for the three low-half FP store/convert lanes (u1, u3, u5). Each cycle it captures up to three 14-bit retire words from the lanes' ret/ret_en outputs, compacts them in lane order into a circular buffer, and presents the two oldest entries to the retire unit. A registered stall signal back-pressures lane issue before the buffer can overflow.

## Interface
- DEPTH, 8, buffer entries; power of two, minimum 4
- RET_W, 14, retire word width
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low
- u1_ret  input  RET_W  lane-1 retire word
- u1_ret_en  input  1  lane-1 word valid
- u3_ret  input  RET_W  lane-3 retire word
- u3_ret_en  input  1  lane-3 word valid
- u5_ret  input  RET_W  lane-5 retire word
- u5_ret_en  input  1  lane-5 word valid
- out0_ret  output  RET_W  oldest entry
- out0_vld  output  1  out0_ret valid
- out1_ret  output  RET_W  second-oldest entry
- out1_vld  output  1  out1_ret valid
- out_take  input  2  consumer dequeue: 00 none, 01 take out0, 11 take out0+out1
- stall  output  1  registered; lanes must not assert ret_en the cycle after stall=1
- count  output  log2(DEPTH)+1  current occupancy
- err  output  1  sticky protocol/overflow error

## Operation
- State: head and tail pointers (log2(DEPTH) bits, wrap mod DEPTH), occupancy count, entry array, stall flop, err flop.
- Enqueue: enabled lanes written in fixed order u1, u3, u5, compacted; first enabled lane at tail, next at tail+1, etc. Disabled lanes leave no gap. tail advances by number written.
- Dequeue: out0 = entry[head], out1 = entry[head+1]. out0_vld = count>=1, out1_vld = count>=2. Both are functions of registered state only (no input-to-output path).
- out_take 01 effective only when out0_vld; 11 effective only when out1_vld. head advances by effective take count.
- out_take 10: illegal; no dequeue, err set. out_take 01 with out0_vld=0 or 11 with out1_vld=0: no dequeue (or single dequeue for 11 with only out0_vld), err set.
- Simultaneous enq/deq: space available for enqueue = DEPTH - count + effective takes this cycle. Writes beyond available space dropped (highest-order lanes dropped first: u5, then u3, then u1); err set.
- count_next = count + accepted writes - effective takes.
- stall_next = (DEPTH - count_next) < 3.
- err clears only on reset.
- Entry storage not reset; only pointers, count, stall, err are reset.

## Timing
- Reset (rst=0, asynchronous): head=0, tail=0, count=0, stall=0, err=0; out0_vld=0, out1_vld=0; out0_ret/out1_ret don't-care while invalid.
- Write latency: word presented with ret_en in cycle N visible on out0/out1 in cycle N+1 at earliest (no bypass).
- Dequeue takes effect on the edge ending the cycle out_take is sampled; next entries shown in cycle N+1.
- stall reflects occupancy after the edge; a lane seeing stall=1 in cycle N issues nothing in N. Lanes already in flight are covered by the 3-entry headroom.
- Reset asserted mid-operation discards all buffered entries immediately; deassertion synchronous to clk by system reset logic.

## Test plan
- Reset: hold rst=0, release -> count=0, out0_vld=0, out1_vld=0, stall=0, err=0.
- Triple write: u1_ret=14'h0011, u3_ret=14'h0033, u5_ret=14'h0055, all en=1 one cycle -> next cycle count=3, out0_ret=0011, out1_ret=0033; take 11 -> out0_ret=0055, count=1.
- Compaction: only u3_en (0x0A3) and u5_en (0x0A5) -> out0_ret=0A3, out1_ret=0A5, count=2.
- Wrap and stall (DEPTH=8): fill 6 entries -> stall=1; take 11 with three new writes same cycle -> count=7, stall=1, no err; drain and refill across pointer wrap, FIFO order preserved for 20 words.
- Overflow: count=7, three writes, take=00 -> u1 accepted, u3/u5 dropped, count=8, err=1 sticky.
- Illegal take: count=2, out_take=10 -> count stays 2, err=1; subsequent reset clears err.
